// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings for the UART transmit block
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int CTRL_TXEN  = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_FULL  = 2;
    localparam int CTRL_OVR   = 3;
    localparam int CTRL_BUSY  = 4;

    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period down-counter producing a bit_end pulse
module uart_baud_gen #(
    parameter int BAUD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load,
    input  logic [BAUD_W-1:0] bauddiv,
    output logic              bit_end
);

    logic [BAUD_W-1:0] cnt;

    // A load cycle never ends a bit, so the first period of a frame is full length.
    assign bit_end = run & ~load & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= bauddiv;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= bauddiv;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_regs.sv
// rtl/uart_tx_regs.sv - UART TX register file (CTRL, BAUDDIV, holding reg) and 8N1 serialiser
module uart_tx_regs
    import uart_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BAUD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_tr,
    input  logic              sel_ctrl,
    input  logic              sel_baud,
    input  logic              enable,
    input  logic              write,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_irq
);

    logic              wr_tr;
    logic              wr_ctrl;
    logic              wr_baud;

    logic              tx_en;
    logic              irq_en;
    logic              hold_full;
    logic              overrun;
    logic [7:0]        hold_data;
    logic [BAUD_W-1:0] bauddiv;

    tx_state_t         state;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;

    logic              bit_end;
    logic              start_idle;
    logic              start_b2b;
    logic              load_hold;
    logic              wr_accept;
    logic [4:0]        ctrl_rd;
    logic              unused_wdata;

    assign wr_tr   = sel_tr   & enable & write;
    assign wr_ctrl = sel_ctrl & enable & write;
    assign wr_baud = sel_baud & enable & write;

    assign start_idle = (state == IDLE) & tx_en & hold_full;
    assign start_b2b  = (state == STOP) & bit_end & tx_en & hold_full;
    assign load_hold  = start_idle | start_b2b;

    // The holding register can be refilled in the same cycle the FSM drains it.
    assign wr_accept  = wr_tr & (~hold_full | load_hold);

    assign tx_busy = (state != IDLE);
    assign tx_irq  = irq_en & ~hold_full;

    assign unused_wdata = &{1'b0, wdata[DATA_W-1:BAUD_W]};

    uart_baud_gen #(
        .BAUD_W (BAUD_W)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (tx_busy),
        .load    (start_idle),
        .bauddiv (bauddiv),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en     <= 1'b0;
            irq_en    <= 1'b0;
            bauddiv   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                tx_en  <= wdata[CTRL_TXEN];
                irq_en <= wdata[CTRL_IRQEN];
            end
            if (wr_baud) begin
                bauddiv <= wdata[BAUD_W-1:0];
            end
            if (wr_accept) begin
                hold_data <= wdata[7:0];
            end
            if (wr_accept) begin
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
            if (wr_tr & ~wr_accept) begin
                overrun <= 1'b1;
            end else if (wr_ctrl & wdata[CTRL_OVR]) begin
                overrun <= 1'b0;
            end
        end
    end

    // txd is assigned the value for the state being entered, so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (start_idle) begin
                        shift <= hold_data;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (start_b2b) begin
                            shift <= hold_data;
                            state <= START;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_rd = {tx_busy, overrun, hold_full, irq_en, tx_en};

    always_comb begin
        rdata = '0;
        if (sel_tr) begin
            rdata[7:0] = hold_data;
        end else if (sel_ctrl) begin
            rdata[4:0] = ctrl_rd;
        end else if (sel_baud) begin
            rdata[BAUD_W-1:0] = bauddiv;
        end
    end

endmodule
